// File: rtl/csi2rx_eight_lane_lml_if.sv
`default_nettype none
// ============================================================================
// Module  : csi2rx_eight_lane_lml_if
// Purpose : PPI receive and FIFO write bundle of the eight-lane merging layer.
// Revision: 1.0 - initial release
// ============================================================================
interface csi2rx_eight_lane_lml_if;
  logic        eight_lane_en;
  logic [7:0]  rxactivehs;
  logic [7:0]  rxvalidhs;
  logic [7:0]  rxsynchs;
  logic [63:0] rxdatahs;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [63:0] fifo_wr_data;
  logic [7:0]  fifo_wr_strb;
  logic        eop_wr;
  logic        header_info;
  logic [5:0]  data_type;
  logic [1:0]  virtual_channel;
  logic [15:0] word_cnt;
  logic        short_packet;
  logic        rx_done;
  logic        lane_err;
  logic        trunc_err;
  logic        ovf_err;

  modport slave (
    input  eight_lane_en, rxactivehs, rxvalidhs, rxsynchs, rxdatahs, fifo_full,
    output fifo_wr_en, fifo_wr_data, fifo_wr_strb, eop_wr, header_info,
           data_type, virtual_channel, word_cnt, short_packet,
           rx_done, lane_err, trunc_err, ovf_err
  );

  modport master (
    output eight_lane_en, rxactivehs, rxvalidhs, rxsynchs, rxdatahs, fifo_full,
    input  fifo_wr_en, fifo_wr_data, fifo_wr_strb, eop_wr, header_info,
           data_type, virtual_channel, word_cnt, short_packet,
           rx_done, lane_err, trunc_err, ovf_err
  );
endinterface
`default_nettype wire

// File: rtl/csi2rx_eight_lane_lml.sv
`default_nettype none
// ============================================================================
// Module  : csi2rx_eight_lane_lml
// Purpose : Merges eight deskewed HS lanes into 64-bit FIFO beats with strobe/EOP.
// Revision: 1.0 - initial release
// ============================================================================
module csi2rx_eight_lane_lml (
  input  wire                           rxbyteclkhs,
  input  wire                           rxbyteclkhs_rst_n,
  csi2rx_eight_lane_lml_if.slave        bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PAYLOAD  = 2'd1;
  localparam logic [1:0] S_WAIT_EOT = 2'd2;

  function automatic logic [7:0] f_mask(input logic [3:0] n);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = (4'(i) < n);
    return m;
  endfunction

  logic [1:0]  r_state;
  logic [16:0] r_rem;
  logic        r_wr_en;
  logic [63:0] r_wr_data;
  logic [7:0]  r_wr_strb;
  logic        r_eop;
  logic        r_hdr;
  logic [5:0]  r_dt;
  logic [1:0]  r_vc;
  logic [15:0] r_wc;
  logic        r_short;
  logic        r_done;
  logic        r_lane_err;
  logic        r_trunc;
  logic        r_ovf;

  logic        w_hdr_hit;
  logic [7:0]  w_di;
  logic [15:0] w_wc;
  logic        w_short;
  logic [16:0] w_total;
  logic [7:0]  w_hdr_strb;
  logic [7:0]  w_pay_strb;
  logic        w_unused;

  assign w_hdr_hit  = bus.rxactivehs[0] & bus.rxvalidhs[0] & bus.rxsynchs[0];
  assign w_di       = bus.rxdatahs[7:0];
  assign w_wc       = {bus.rxdatahs[23:16], bus.rxdatahs[15:8]};
  assign w_short    = (w_di[5:0] <= 6'h0F);
  assign w_total    = w_short ? 17'd4 : ({1'b0, w_wc} + 17'd6);
  assign w_hdr_strb = f_mask((w_total >= 17'd8) ? 4'd8 : w_total[3:0]);
  assign w_pay_strb = f_mask((r_rem >= 17'd8) ? 4'd8 : r_rem[3:0]);
  // ECC byte and the non-reference lane strobes are intentionally not consumed.
  assign w_unused   = ^{bus.rxdatahs[31:24], bus.rxactivehs[7:1], bus.rxsynchs[7:1]};

  always_ff @(posedge rxbyteclkhs or negedge rxbyteclkhs_rst_n) begin
    if (!rxbyteclkhs_rst_n) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_wr_strb  <= '0;
      r_eop      <= 1'b0;
      r_hdr      <= 1'b0;
      r_dt       <= '0;
      r_vc       <= '0;
      r_wc       <= '0;
      r_short    <= 1'b0;
      r_done     <= 1'b0;
      r_lane_err <= 1'b0;
      r_trunc    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_wr_en    <= 1'b0;
      r_eop      <= 1'b0;
      r_hdr      <= 1'b0;
      r_done     <= 1'b0;
      r_lane_err <= 1'b0;
      r_trunc    <= 1'b0;
      r_ovf      <= 1'b0;
      if (!bus.eight_lane_en) begin
        r_state   <= S_IDLE;
        r_rem     <= '0;
        r_wr_data <= '0;
        r_wr_strb <= '0;
        r_dt      <= '0;
        r_vc      <= '0;
        r_wc      <= '0;
        r_short   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_hdr_hit) begin
              // A dropped beat still advances the packet so framing stays aligned.
              r_wr_en    <= ~bus.fifo_full;
              r_ovf      <= bus.fifo_full;
              r_hdr      <= ~bus.fifo_full;
              r_wr_data  <= bus.rxdatahs;
              r_wr_strb  <= w_hdr_strb;
              r_lane_err <= (bus.rxvalidhs != w_hdr_strb);
              r_dt       <= w_di[5:0];
              r_vc       <= w_di[7:6];
              r_wc       <= w_wc;
              r_short    <= w_short;
              if (w_total <= 17'd8) begin
                r_eop   <= ~bus.fifo_full;
                r_state <= S_WAIT_EOT;
              end else begin
                r_rem   <= w_total - 17'd8;
                r_state <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (!bus.rxactivehs[0]) begin
              r_trunc <= 1'b1;
              r_done  <= 1'b1;
              r_rem   <= '0;
              r_state <= S_IDLE;
            end else if (bus.rxvalidhs[0]) begin
              r_wr_en    <= ~bus.fifo_full;
              r_ovf      <= bus.fifo_full;
              r_wr_data  <= bus.rxdatahs;
              r_wr_strb  <= w_pay_strb;
              r_lane_err <= (bus.rxvalidhs != w_pay_strb);
              if (r_rem <= 17'd8) begin
                r_eop   <= ~bus.fifo_full;
                r_rem   <= '0;
                r_state <= S_WAIT_EOT;
              end else begin
                r_rem <= r_rem - 17'd8;
              end
            end
          end
          S_WAIT_EOT: begin
            if (!bus.rxactivehs[0]) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.fifo_wr_en      = r_wr_en;
  assign bus.fifo_wr_data    = r_wr_data;
  assign bus.fifo_wr_strb    = r_wr_strb;
  assign bus.eop_wr          = r_eop;
  assign bus.header_info     = r_hdr;
  assign bus.data_type       = r_dt;
  assign bus.virtual_channel = r_vc;
  assign bus.word_cnt        = r_wc;
  assign bus.short_packet    = r_short;
  assign bus.rx_done         = r_done;
  assign bus.lane_err        = r_lane_err;
  assign bus.trunc_err       = r_trunc;
  assign bus.ovf_err         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_csi2rx_eight_lane_lml.sv
`default_nettype none
// ============================================================================
// Module  : tb_csi2rx_eight_lane_lml
// Purpose : Directed self-checking bench for the eight-lane merging layer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_csi2rx_eight_lane_lml;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  csi2rx_eight_lane_lml_if u_if ();

  csi2rx_eight_lane_lml u_dut (
    .rxbyteclkhs       (clk),
    .rxbyteclkhs_rst_n (rst_n),
    .bus               (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
    return {32'hC0DE_0000, ecc, wc[15:8], wc[7:0], di};
  endfunction

  // Drive one cycle of PPI inputs, then settle just after the capturing edge.
  task automatic cyc(input logic [7:0] act, input logic [7:0] val, input logic [7:0] syn,
                     input logic [63:0] d, input logic full);
    @(negedge clk);
    u_if.rxactivehs = act;
    u_if.rxvalidhs  = val;
    u_if.rxsynchs   = syn;
    u_if.rxdatahs   = d;
    u_if.fifo_full  = full;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(8'h00, 8'h00, 8'h00, 64'h0, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    u_if.eight_lane_en = 1'b1;
    u_if.rxactivehs = '0;
    u_if.rxvalidhs  = '0;
    u_if.rxsynchs   = '0;
    u_if.rxdatahs   = '0;
    u_if.fifo_full  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_wr_en",  u_if.fifo_wr_en, 0);
    check_val("rst_strb",   u_if.fifo_wr_strb, 0);
    check_val("rst_dtype",  u_if.data_type, 0);
    check_val("rst_wc",     u_if.word_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Short packet DI=00 WC=0001
    cyc(8'hFF, 8'h0F, 8'h01, hdr(8'h00, 16'h0001, 8'h3F), 1'b0);
    check_val("sp_wr_en", u_if.fifo_wr_en, 1);
    check_val("sp_strb",  u_if.fifo_wr_strb, 8'h0F);
    check_val("sp_hdr",   u_if.header_info, 1);
    check_val("sp_eop",   u_if.eop_wr, 1);
    check_val("sp_short", u_if.short_packet, 1);
    check_val("sp_data",  u_if.fifo_wr_data, 64'hC0DE_0000_3F00_0100);
    check_val("sp_lerr",  u_if.lane_err, 0);
    idle_cyc();
    check_val("sp_done",  u_if.rx_done, 1);
    check_val("sp_trunc", u_if.trunc_err, 0);
    check_val("sp_wr_en2", u_if.fifo_wr_en, 0);
    idle_cyc();
    check_val("sp_done_pulse", u_if.rx_done, 0);

    // Long packet DI=2A WC=000C, 18 bytes over three beats
    cyc(8'hFF, 8'hFF, 8'h01, hdr(8'h2A, 16'h000C, 8'h11), 1'b0);
    check_val("lp_b1_strb", u_if.fifo_wr_strb, 8'hFF);
    check_val("lp_b1_hdr",  u_if.header_info, 1);
    check_val("lp_b1_eop",  u_if.eop_wr, 0);
    check_val("lp_wc",      u_if.word_cnt, 16'h000C);
    check_val("lp_dt",      u_if.data_type, 6'h2A);
    check_val("lp_short",   u_if.short_packet, 0);
    cyc(8'hFF, 8'hFF, 8'h01, 64'h1111_2222_3333_4444, 1'b0);
    check_val("lp_b2_wr",   u_if.fifo_wr_en, 1);
    check_val("lp_b2_strb", u_if.fifo_wr_strb, 8'hFF);
    check_val("lp_b2_hdr",  u_if.header_info, 0);
    check_val("lp_b2_eop",  u_if.eop_wr, 0);
    check_val("lp_b2_data", u_if.fifo_wr_data, 64'h1111_2222_3333_4444);
    cyc(8'hFF, 8'h03, 8'h00, 64'h0000_0000_0000_BEEF, 1'b0);
    check_val("lp_b3_strb", u_if.fifo_wr_strb, 8'h03);
    check_val("lp_b3_eop",  u_if.eop_wr, 1);
    check_val("lp_b3_lerr", u_if.lane_err, 0);
    cyc(8'hFF, 8'hFF, 8'h00, 64'hFFFF, 1'b0);
    check_val("lp_trailer", u_if.fifo_wr_en, 0);
    idle_cyc();
    check_val("lp_done", u_if.rx_done, 1);

    // WC=0002: total 8, header and EOP on the same beat; back-to-back header
    cyc(8'hFF, 8'hFF, 8'h01, hdr(8'h2A, 16'h0002, 8'h22), 1'b0);
    check_val("b8_strb", u_if.fifo_wr_strb, 8'hFF);
    check_val("b8_hdr",  u_if.header_info, 1);
    check_val("b8_eop",  u_if.eop_wr, 1);
    idle_cyc();
    check_val("b8_done", u_if.rx_done, 1);

    // Truncation: WC=0100, burst ends after 5 beats
    cyc(8'hFF, 8'hFF, 8'h01, hdr(8'h2B, 16'h0100, 8'h33), 1'b0);
    for (int i = 0; i < 4; i++) cyc(8'hFF, 8'hFF, 8'h00, 64'(i), 1'b0);
    check_val("tr_b5_eop", u_if.eop_wr, 0);
    check_val("tr_b5_wr",  u_if.fifo_wr_en, 1);
    idle_cyc();
    check_val("tr_trunc", u_if.trunc_err, 1);
    check_val("tr_done",  u_if.rx_done, 1);
    check_val("tr_eop",   u_if.eop_wr, 0);
    check_val("tr_wr",    u_if.fifo_wr_en, 0);
    // Recovery with a short packet on VC1 (DI=41)
    cyc(8'hFF, 8'h0F, 8'h01, hdr(8'h41, 16'h1234, 8'h44), 1'b0);
    check_val("rc_wr",    u_if.fifo_wr_en, 1);
    check_val("rc_hdr",   u_if.header_info, 1);
    check_val("rc_eop",   u_if.eop_wr, 1);
    check_val("rc_vc",    u_if.virtual_channel, 2'd1);
    check_val("rc_dt",    u_if.data_type, 6'h01);
    check_val("rc_trunc", u_if.trunc_err, 0);
    idle_cyc();

    // Overflow on beat 2 and lane error on beat 3: WC=0012, 24 bytes
    cyc(8'hFF, 8'hFF, 8'h01, hdr(8'h2C, 16'h0012, 8'h55), 1'b0);
    check_val("of_b1_wr", u_if.fifo_wr_en, 1);
    cyc(8'hFF, 8'hFF, 8'h00, 64'hAAAA, 1'b1);
    check_val("of_b2_wr",  u_if.fifo_wr_en, 0);
    check_val("of_b2_ovf", u_if.ovf_err, 1);
    check_val("of_b2_eop", u_if.eop_wr, 0);
    cyc(8'hFF, 8'h7F, 8'h00, 64'hBBBB, 1'b0);
    check_val("of_b3_wr",   u_if.fifo_wr_en, 1);
    check_val("of_b3_strb", u_if.fifo_wr_strb, 8'hFF);
    check_val("of_b3_eop",  u_if.eop_wr, 1);
    check_val("of_b3_lerr", u_if.lane_err, 1);
    check_val("of_b3_ovf",  u_if.ovf_err, 0);
    idle_cyc();
    check_val("of_done", u_if.rx_done, 1);

    // Reset mid-packet
    cyc(8'hFF, 8'hFF, 8'h01, hdr(8'h2D, 16'h0100, 8'h66), 1'b0);
    cyc(8'hFF, 8'hFF, 8'h00, 64'hCCCC, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mr_wr",   u_if.fifo_wr_en, 0);
    check_val("mr_data", u_if.fifo_wr_data, 0);
    check_val("mr_wc",   u_if.word_cnt, 0);
    check_val("mr_dt",   u_if.data_type, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // A payload-looking beat without sync must not be taken as a beat in IDLE
    cyc(8'hFF, 8'hFF, 8'h00, 64'hDDDD, 1'b0);
    check_val("mr_idle", u_if.fifo_wr_en, 0);
    cyc(8'hFF, 8'h0F, 8'h01, hdr(8'h03, 16'h0000, 8'h77), 1'b0);
    check_val("mr_hdr",  u_if.header_info, 1);
    check_val("mr_strb", u_if.fifo_wr_strb, 8'h0F);
    idle_cyc();

    // Enable low mid-packet forces IDLE and clears outputs
    cyc(8'hFF, 8'hFF, 8'h01, hdr(8'h2E, 16'h0100, 8'h88), 1'b0);
    @(negedge clk);
    u_if.eight_lane_en = 1'b0;
    cyc(8'hFF, 8'hFF, 8'h00, 64'hEEEE, 1'b0);
    check_val("en_wr", u_if.fifo_wr_en, 0);
    check_val("en_wc", u_if.word_cnt, 0);
    @(negedge clk);
    u_if.eight_lane_en = 1'b1;
    cyc(8'hFF, 8'h0F, 8'h01, hdr(8'h05, 16'h0000, 8'h99), 1'b0);
    check_val("en_hdr", u_if.header_info, 1);
    check_val("en_dt",  u_if.data_type, 6'h05);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csi2rx_eight_lane_lml.md
# csi2rx_eight_lane_lml

Eight-lane lane merging layer for the CSI-2 receive path. It sits between the D-PHY PPI receive interface and the receive byte FIFO. It merges the eight per-lane HS byte streams into 64-bit beats, decodes the packet header, and tracks the remaining packet bytes. Each beat is written to the FIFO with a byte strobe and an end-of-packet tag. It is the receive-side counterpart of the eight-lane lane distribution layer.

## Interface
- Parameters: none; lane count fixed at 8, data width fixed at 64.
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are rxbyteclkhs / rxbyteclkhs_rst_n.
- rxbyteclkhs  input  1  HS receive byte clock.
- rxbyteclkhs_rst_n  input  1  asynchronous active-low reset.
- eight_lane_en  input  1  block enable; low forces IDLE.
- rxactivehs  input  8  per-lane HS active; lane 0 is the reference.
- rxvalidhs  input  8  per-lane byte valid; lanes are deskewed by the PHY.
- rxsynchs  input  8  per-lane sync-detected pulse; lane 0 is used.
- rxdatahs  input  64  byte n on [8n+7:8n]; packet byte k arrives on lane k mod 8.
- fifo_full  input  1  receive FIFO full.
- fifo_wr_en  output  1  FIFO write.
- fifo_wr_data  output  64  merged beat.
- fifo_wr_strb  output  8  valid-byte mask, thermometer from bit 0.
- eop_wr  output  1  tags the last beat of a packet.
- header_info  output  1  tags the header beat.
- data_type  output  6  DI[5:0] of the current packet, held until the next header.
- virtual_channel  output  2  DI[7:6].
- word_cnt  output  16  header WC, {byte2, byte1}.
- short_packet  output  1  data_type <= 6'h0F.
- rx_done  output  1  one-cycle pulse at end of HS burst.
- lane_err  output  1  one-cycle pulse: rxvalidhs differs from the expected mask on an accepted beat.
- trunc_err  output  1  one-cycle pulse: HS burst ended before the packet completed.
- ovf_err  output  1  one-cycle pulse: beat dropped because fifo_full was high.

## Operation
- States: IDLE, PAYLOAD, WAIT_EOT.
- Reset, eight_lane_en=0: state returns to IDLE, rem_cnt is cleared, and all outputs go to 0 on the next edge. Header registers are also cleared.
- Header beat (IDLE): occurs when rxactivehs[0] & rxvalidhs[0] & rxsynchs[0] are all high.
  - Capture DI, WC and ECC from bytes 0–3. ECC is not checked here.
  - total = 4 for short packets; WC+6 for long packets (17-bit arithmetic, no overflow).
  - Write the beat with strobe = mask(min(8,total)) and header_info=1.
  - If total <= 8: eop_wr=1 and go to WAIT_EOT.
  - Else: rem_cnt = total-8 and go to PAYLOAD.
- PAYLOAD: each cycle with rxvalidhs[0]=1 is a beat.
  - Strobe = mask(min(8,rem_cnt)).
  - rem_cnt -= min(8,rem_cnt).
  - When rem_cnt <= 8: eop_wr=1 and go to WAIT_EOT.
- mask(n): low n bits set; mask(4)=8'h0F, mask(8)=8'hFF.
- lane_err: on any accepted beat where rxvalidhs != expected strobe. The beat is still written with the expected strobe.
- WAIT_EOT: further valid bytes (trailer) are ignored. When rxactivehs[0]=0, go to IDLE and pulse rx_done.
- Truncation: rxactivehs[0]=0 in PAYLOAD. Go to IDLE and pulse trunc_err and rx_done in the same cycle. No eop_wr is issued.
- Overflow: a beat arriving while fifo_full=1 is not written. ovf_err pulses, and rem_cnt and state advance as if the beat had been written.
- rxsynchs[0] outside IDLE is ignored.

## Timing
- All outputs are registered. A beat sampled at edge N appears on fifo_wr_* at N+1, with no gaps added.
- data_type, virtual_channel, word_cnt and short_packet update at the same edge as the header beat's fifo_wr_en.
- rx_done and trunc_err assert one cycle after rxactivehs[0] is sampled low.
- A new header is accepted the cycle after returning to IDLE. Back-to-back bursts need no idle gap beyond that one cycle.
- No backpressure is applied to the PHY; throughput is one beat per clock.

## Test plan
- Short packet: DI=8'h00, WC=16'h0001, rxvalidhs=8'h0F, one beat, then rxactivehs drops.
  - One write with strb=8'h0F, header_info=1, eop_wr=1, short_packet=1.
  - rx_done one cycle after rxactivehs drops.
- Long packet, DI=8'h2A, WC=16'h000C (18 bytes), beats with rxvalidhs 8'hFF, 8'hFF, 8'h03.
  - Three writes with strb 8'hFF, 8'hFF, 8'h03; eop_wr on the third.
  - word_cnt=16'h000C, data_type=6'h2A.
- WC=16'h0002 (total 8): a single beat with strb=8'hFF carries both header_info=1 and eop_wr=1.
- Truncation: WC=16'h0100, rxactivehs[0] drops after 5 beats.
  - trunc_err=1 and rx_done=1 in the same cycle, no eop_wr, state IDLE.
  - The next packet is received cleanly.
- Overflow and lane error, WC=16'h0012 (24 bytes, three beats):
  - fifo_full=1 on beat 2: beat 2 is not written, ovf_err=1, beat 3 is written with eop_wr.
  - rxvalidhs=8'h7F on beat 3: lane_err=1.
- Reset mid-packet: assert reset in PAYLOAD. All outputs read 0 and the state is IDLE; the next header is accepted after reset is released.
